// File: rtl/vga_rx_decoder_if.sv
// Video bus between a VGA timing generator (master) and the receive decoder (slave).
interface vga_rx_decoder_if;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;

  modport master (output hsync, vsync, red, green, blue);
  modport slave  (input  hsync, vsync, red, green, blue);
endinterface

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: recovers line/frame timing from hsync/vsync, locks after clean frames,
// emits active-area pixels. Define VGA_RX_CRC_EN to add a per-frame CRC-16-CCITT of px_data.
module vga_rx_decoder #(
  parameter int HPIXELS     = 800,
  parameter int VLINES      = 521,
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                dclk,
  input  logic                clr,
  vga_rx_decoder_if.slave     vid,
  output logic [9:0]          px_x,
  output logic [9:0]          px_y,
  output logic [7:0]          px_data,
  output logic                px_valid,
  output logic                locked,
  output logic                err_hlen,
  output logic                err_vlen,
  output logic                frame_done,
  output logic [15:0]         frame_crc
);

  localparam logic [10:0] HPIX_W = 11'(HPIXELS);
  localparam logic [10:0] VLIN_W = 11'(VLINES);
  localparam logic [9:0]  HBP_W  = 10'(HBP);
  localparam logic [9:0]  HFP_W  = 10'(HFP);
  localparam logic [9:0]  VBP_W  = 10'(VBP);
  localparam logic [9:0]  VFP_W  = 10'(VFP);
  localparam int          GW     = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] LOCK_W = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t state, state_nx;
  logic [GW-1:0] good, good_nx;

  logic       hs1, vs1, hs_prev, vs_edge;
  logic [7:0] rgb1;
  logic [9:0] hcnt, vcnt, hcnt_nx, vcnt_nx;
  logic       first_h, first_v;
  logic       hedge, fstart, hlen_bad, vlen_bad, pix_ok, enter_search;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      rgb1    <= '0;
      hs_prev <= 1'b1;
      vs_edge <= 1'b1;
    end else begin
      hs1     <= vid.hsync;
      vs1     <= vid.vsync;
      rgb1    <= {vid.red, vid.green, vid.blue};
      hs_prev <= hs1;
      if (hedge) vs_edge <= vs1;
    end
  end

  // hcnt_nx/vcnt_nx are the coordinates of the stage-1 sample; the registers hold the previous one.
  always_comb begin
    hedge    = !hs1 && hs_prev;
    fstart   = hedge && !vs1 && vs_edge;
    hcnt_nx  = hedge ? '0 : ((hcnt == 10'h3FF) ? hcnt : hcnt + 10'd1);
    if (fstart)     vcnt_nx = '0;
    else if (hedge) vcnt_nx = (vcnt == 10'h3FF) ? vcnt : vcnt + 10'd1;
    else            vcnt_nx = vcnt;
    hlen_bad = (hedge && !first_h && ({1'b0, hcnt} + 11'd1) != HPIX_W) ||
               (!hedge && hcnt == 10'd1022);
    vlen_bad = fstart && !first_v && ({1'b0, vcnt} + 11'd1) != VLIN_W;
    pix_ok   = (state == LOCKED) &&
               (hcnt_nx >= HBP_W) && (hcnt_nx < HFP_W) &&
               (vcnt_nx >= VBP_W) && (vcnt_nx < VFP_W);
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hcnt       <= '0;
      vcnt       <= '0;
      first_h    <= 1'b1;
      first_v    <= 1'b1;
      px_valid   <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      px_data    <= '0;
      err_hlen   <= 1'b0;
      err_vlen   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      hcnt       <= hcnt_nx;
      vcnt       <= vcnt_nx;
      px_valid   <= pix_ok;
      px_x       <= pix_ok ? hcnt_nx - HBP_W : '0;
      px_y       <= pix_ok ? vcnt_nx - VBP_W : '0;
      px_data    <= pix_ok ? rgb1 : '0;
      err_hlen   <= hlen_bad;
      err_vlen   <= vlen_bad;
      frame_done <= fstart;
      if (enter_search) begin
        first_h <= 1'b1;
        first_v <= 1'b1;
      end else begin
        if (hedge)  first_h <= 1'b0;
        if (fstart) first_v <= 1'b0;
      end
    end
  end

  // The FSM acts on the registered pulses, so locked follows an error by one cycle.
  always_comb begin
    state_nx = state;
    good_nx  = good;
    case (state)
      SEARCH: if (frame_done) begin
        state_nx = VERIFY;
        good_nx  = '0;
      end
      VERIFY: begin
        if (err_hlen || err_vlen) state_nx = SEARCH;
        else if (frame_done) begin
          if ((good + GW'(1)) == LOCK_W) state_nx = LOCKED;
          else                           good_nx  = good + GW'(1);
        end
      end
      LOCKED: if (err_hlen || err_vlen) state_nx = SEARCH;
      default: state_nx = SEARCH;
    endcase
    enter_search = (state != SEARCH) && (state_nx == SEARCH);
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state <= SEARCH;
      good  <= '0;
    end else begin
      state <= state_nx;
      good  <= good_nx;
    end
  end

  assign locked = (state == LOCKED);

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int unsigned i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      crc       <= '1;
      frame_crc <= '0;
    end else if (frame_done) begin
      frame_crc <= crc;
      crc       <= '1;
    end else if (px_valid) begin
      crc <= crc_byte(crc, px_data);
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Randomised bench for vga_rx_decoder on a reduced 40x20 timing; a timestamp-based
// reference model predicts every output each cycle, plus targeted scenario checks.
module tb_vga_rx_decoder;
  localparam int HP = 40, VL = 20, HBP = 8, HFP = 36, VBP = 3, VFP = 17, LF = 2;
  localparam int HSW = 5, VSW = 2;
`ifdef VGA_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        dclk = 1'b0, clr = 1'b1;
  logic [9:0]  px_x, px_y;
  logic [7:0]  px_data;
  logic        px_valid, locked, err_hlen, err_vlen, frame_done;
  logic [15:0] frame_crc;

  vga_rx_decoder_if vif ();

  vga_rx_decoder #(.HPIXELS(HP), .VLINES(VL), .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP),
                   .LOCK_FRAMES(LF)) dut (
    .dclk(dclk), .clr(clr), .vid(vif), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .px_valid(px_valid), .locked(locked), .err_hlen(err_hlen), .err_vlen(err_vlen),
    .frame_done(frame_done), .frame_crc(frame_crc));

  always #5 dclk = ~dclk;

  typedef struct packed {
    logic pv; logic [9:0] x; logic [9:0] y; logic [7:0] d;
    logic lk; logic eh; logic ev; logic fd; logic [15:0] crc;
  } obs_t;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc8(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {px_valid, px_x, px_y, px_data, locked, err_hlen, err_vlen, frame_done, frame_crc};
    return o;
  endfunction

  // Reference model: positions come from sample timestamps of the last hsync fall and
  // the edge index of the last frame start.
  int   k = 0, last_fall, edges, fs_idx, good;
  bit   searching, lk_m, ex_h, ex_v, prev_hs, edge_vs;
  logic [15:0] acc, m_fcrc;
  obs_t e_cur, e_nxt;

  task automatic model_reset();
    searching = 1; lk_m = 0; good = 0; ex_h = 1; ex_v = 1;
    prev_hs = 1; edge_vs = 1; edges = 0; fs_idx = -1; last_fall = k - 2;
    acc = 16'hFFFF; m_fcrc = 16'h0; e_cur = '0; e_nxt = '0;
  endtask

  task automatic model_step(input logic hs, input logic vs, input logic [7:0] rgb);
    int col, row, lines;
    bit edge_, fs;
    if (searching) begin
      if (e_cur.fd) begin searching = 0; good = 0; end
    end else if (e_cur.eh || e_cur.ev) begin
      searching = 1; lk_m = 0; ex_h = 1; ex_v = 1;
    end else if (!lk_m && e_cur.fd) begin
      good++;
      if (good == LF) lk_m = 1;
    end
    if (e_cur.fd) begin m_fcrc = acc; acc = 16'hFFFF; end
    else if (e_cur.pv) acc = crc8(acc, e_cur.d);
    e_cur = e_nxt;
    e_cur.lk = lk_m;
    e_cur.crc = CRC_ON ? m_fcrc : 16'h0;
    e_nxt = '0;
    edge_ = prev_hs && !hs;
    prev_hs = hs;
    if (edge_) begin
      if (!ex_h && (k - last_fall) != HP) e_nxt.eh = 1;
      ex_h = 0;
      last_fall = k;
      fs = !vs && edge_vs;
      edge_vs = vs;
      if (fs) begin
        lines = sat(edges - 1 - fs_idx) + 1;
        if (!ex_v && lines != VL) e_nxt.ev = 1;
        ex_v = 0;
        fs_idx = edges;
        e_nxt.fd = 1;
      end
      edges++;
    end else if (k - last_fall == 1023) e_nxt.eh = 1;
    col = sat(k - last_fall);
    row = sat(edges - 1 - fs_idx);
    if (lk_m && col >= HBP && col < HFP && row >= VBP && row < VFP) begin
      e_nxt.pv = 1;
      e_nxt.x = 10'(col - HBP);
      e_nxt.y = 10'(row - VBP);
      e_nxt.d = rgb;
    end
    k++;
  endtask

  int   cnt_eh, cnt_ev, cnt_fd;
  bit   seen;
  logic [19:0] first_xy;
  logic [7:0]  first_d;
  int   max_x, max_y;

  task automatic clear_stats();
    cnt_eh = 0; cnt_ev = 0; cnt_fd = 0; seen = 0; max_x = 0; max_y = 0;
    first_xy = '1; first_d = '0;
  endtask

  task automatic tick(input logic hs, input logic vs, input logic [7:0] rgb);
    vif.hsync = hs; vif.vsync = vs;
    vif.red = rgb[7:5]; vif.green = rgb[4:2]; vif.blue = rgb[1:0];
    @(posedge dclk);
    model_step(hs, vs, rgb);
    @(negedge dclk);
    check("cyc", {15'd0, dut_obs()}, {15'd0, e_cur});
    if (err_hlen) cnt_eh++;
    if (err_vlen) cnt_ev++;
    if (frame_done) cnt_fd++;
    if (px_valid) begin
      if (!seen) begin first_xy = {px_x, px_y}; first_d = px_data; seen = 1; end
      if (int'(px_x) > max_x) max_x = int'(px_x);
      if (int'(px_y) > max_y) max_y = int'(px_y);
    end
  endtask

  task automatic send_line(input int len, input bit vs_low, input bit white, input int mark_col);
    logic [7:0] rgb;
    for (int c = 0; c < len; c++) begin
      rgb = white ? 8'hFF : 8'($urandom);
      if (c == mark_col) rgb = 8'hE3;
      tick((c < HSW) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1, rgb);
    end
  endtask

  task automatic send_frame(input int nlines = VL, input int bad_line = -1, input int bad_len = HP,
                            input bit white = 0, input bit mark = 0);
    for (int l = 0; l < nlines; l++)
      send_line((l == bad_line) ? bad_len : HP, l < VSW, white, (mark && l == VBP) ? HBP : -1);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    check("clr_zero", {15'd0, dut_obs()}, 64'd0);
    repeat (3) @(negedge dclk);
    clr = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] wcrc;
    vif.hsync = 1; vif.vsync = 1; vif.red = '0; vif.green = '0; vif.blue = '0;
    clear_stats();
    do_reset();

    send_frame(); send_frame();
    check("prelock", {63'd0, locked}, 64'd0);
    send_frame();
    check("lock3", {63'd0, locked}, 64'd1);
    check("no_err", 64'(cnt_eh + cnt_ev), 64'd0);

    clear_stats();
    send_frame(VL, -1, HP, 0, 1);
    check("first_xy", {44'd0, first_xy}, 64'd0);
    check("first_d", {56'd0, first_d}, 64'hE3);
    check("last_x", 64'(max_x), 64'(HFP - HBP - 1));
    check("last_y", 64'(max_y), 64'(VFP - VBP - 1));

    clear_stats();
    send_frame(VL, 5, HP - 1);
    check("hlen_cnt", 64'(cnt_eh), 64'd1);
    check("unlock_h", {63'd0, locked}, 64'd0);
    send_frame(); send_frame(); send_frame();
    check("relock_h", {63'd0, locked}, 64'd1);

    send_frame(VL - 1);
    clear_stats();
    send_frame();
    check("vlen_cnt", 64'(cnt_ev), 64'd1);
    check("fd_cnt", 64'(cnt_fd), 64'd1);
    check("unlock_v", {63'd0, locked}, 64'd0);
    send_frame(); send_frame(); send_frame();
    check("relock_v", {63'd0, locked}, 64'd1);

    clear_stats();
    for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 8'($urandom));
    check("tmo_cnt", 64'(cnt_eh), 64'd1);
    check("unlock_t", {63'd0, locked}, 64'd0);
    send_frame(); send_frame(); send_frame();

    for (int l = 0; l < 8; l++) send_line(HP, l < VSW, 0, -1);
    do_reset();
    send_frame(); send_frame(); send_frame(VL, -1, HP, 1);
    check("relock_c", {63'd0, locked}, 64'd1);
    send_frame();
    wcrc = 16'hFFFF;
    for (int i = 0; i < (HFP - HBP) * (VFP - VBP); i++) wcrc = crc8(wcrc, 8'hFF);
    check("crc_white", {48'd0, frame_crc}, CRC_ON ? {48'd0, wcrc} : 64'd0);

    for (int f = 0; f < 4; f++) begin
      int bl, blen, nl;
      bl   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, VL - 1)) : -1;
      blen = ($urandom_range(0, 1) == 0) ? HP + 1 : HP - 1;
      nl   = ($urandom_range(0, 4) == 0) ? VL + 1 : VL;
      send_frame(nl, bl, blen);
    end
    send_frame();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_rx_decoder.md
VGA_RX_DECODER -- requirements
Module: vga_rx_decoder

Interface
REQ-001 The block SHALL have parameter HPIXELS, default 800, meaning dclk cycles per line.
REQ-002 The block SHALL have parameter VLINES, default 521, meaning lines per frame.
REQ-003 The block SHALL have parameters HBP 144 / HFP 784, meaning first active / first inactive column relative to the hsync falling edge.
REQ-004 The block SHALL have parameters VBP 31 / VFP 511, meaning first active / first inactive line relative to frame start.
REQ-005 The block SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive error-free frames required to lock.
REQ-006 Port: dclk, input, 1, pixel clock (25 MHz); the same clock as the transmitting timing generator.
REQ-007 Port: clr, input, 1, asynchronous active-high reset.
REQ-008 Port: hsync / vsync, input, 1 each, active-low syncs.
REQ-009 Port: red, input, 3; green, input, 3; blue, input, 2; pixel colour.
REQ-010 Port: px_x / px_y, output, 10 each, active-area pixel coordinates.
REQ-011 Port: px_data, output, 8, {red, green, blue} of the decoded pixel.
REQ-012 Port: px_valid, output, 1, high while px_* carries an active pixel.
REQ-013 Port: locked, output, 1, high in state LOCKED.
REQ-014 Port: err_hlen / err_vlen, output, 1 each, one-cycle line-length / frame-length error pulses.
REQ-015 Port: frame_done, output, 1, one-cycle pulse at each detected frame start.
REQ-016 Port: frame_crc, output, 16, checksum of the previous frame.

Function
REQ-017 All inputs SHALL be registered once (stage 1); decode SHALL use stage-1 values only.
REQ-018 An hsync falling edge SHALL be a stage-1 sample with hsync low and the previous sample high; that sample is column 0, so hcnt = 0 on it.
REQ-019 hcnt SHALL otherwise increment by 1 per cycle, saturating at 1023.
REQ-020 A frame start SHALL be an hsync falling edge where vsync is low and vsync was high at the previous hsync falling edge; vcnt = 0 on it.
REQ-021 On a non-frame-start hsync edge, vcnt SHALL increment, saturating at 1023.
REQ-022 On each hsync edge, err_hlen SHALL pulse if the completed line length (hcnt+1) differs from HPIXELS; the first edge after SEARCH entry is exempt.
REQ-023 hcnt reaching 1023 SHALL pulse err_hlen once (timeout).
REQ-024 On each frame start, err_vlen SHALL pulse if the completed frame line count differs from VLINES; the first frame start after SEARCH entry is exempt.
REQ-025 FSM states SHALL be SEARCH, VERIFY and LOCKED.
REQ-026 SEARCH -> VERIFY SHALL occur at the first frame start, with good-frame count = 0.
REQ-027 In VERIFY, each error-free frame start SHALL increment the count; at LOCK_FRAMES the FSM SHALL go to LOCKED.
REQ-028 From VERIFY or LOCKED, any err pulse SHALL return the FSM to SEARCH on the same edge; an error coinciding with the frame start that would lock SHALL take priority.
REQ-029 px_valid SHALL equal locked && HBP<=hcnt<HFP && VBP<=vcnt<VFP.
REQ-030 When px_valid is high, px_x = hcnt-HBP and px_y = vcnt-VBP.
REQ-031 px_x, px_y and px_data SHALL be 0 when px_valid is low.
REQ-032 Latency from input pin to px_* SHALL be 2 dclk.
REQ-033 frame_done SHALL pulse on every frame start in any state.

Reset
REQ-034 clr SHALL asynchronously force state SEARCH, hcnt = vcnt = 0, all outputs 0, and all edge-history registers to 1 (syncs idle).
REQ-035 clr asserted mid-frame SHALL discard partial counts; relock SHALL require a fresh SEARCH -> VERIFY -> LOCKED sequence.

Configuration
REQ-036 Macro VGA_RX_CRC_EN SHALL enable CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, one byte per cycle) over px_data of px_valid pixels.
REQ-037 With VGA_RX_CRC_EN defined, frame_crc SHALL latch the CRC at each frame start and the CRC SHALL reinitialise; frame_crc resets to 0.
REQ-038 Without VGA_RX_CRC_EN, the frame_crc port SHALL remain present and be tied to 0, with no CRC logic.

Verification
REQ-039 Scenario: nominal 800x521 timing, 3 frames -> locked rises at the 3rd frame start; no err pulses.
REQ-040 Scenario: locked; pixel at tx hc=144, vc=31 with rgb=8'hE3 -> 2 cycles later px_valid=1, px_x=0, px_y=0, px_data=8'hE3; last active pixel gives px_x=639, px_y=479.
REQ-041 Scenario: locked; one line of 799 cycles -> err_hlen pulse, locked falls next cycle, relock after 2 more good frames.
REQ-042 Scenario: locked; frame of 520 lines -> err_vlen pulse at frame start, state SEARCH, frame_done still pulses.
REQ-043 Scenario: hsync held high for 1100 cycles -> single err_hlen pulse at hcnt=1023; clr mid-frame -> all outputs 0 immediately.
REQ-044 Scenario: VGA_RX_CRC_EN, all-white frame (px_data=8'hFF x 307200) -> frame_crc matches reference model; without the macro frame_crc=0.
